// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    FETCH,
    STOPPING,
    HALTED
  } ifu_state_e;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and occupancy count; head reads as zero when empty.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     popValid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign popValid = (count != '0);
  assign doPop    = pop && popValid;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign doPush   = push && ((count < CNT_W'(DEPTH)) || doPop);
  assign popData  = popValid ? mem[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem reads, buffers returned
// words and hands {pc, inst} to the core; handles redirects and halt.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output ifu_state_e        dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and the payload is stable while valid is high.
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  ifu_state_e        state;
  ifu_state_e        stateNext;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] rspPc;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflightNext;
  logic [CNT_W-1:0]  dropCnt;
  logic [CNT_W-1:0]  fifoCount;
  logic [OCC_W-1:0]  occupancy;
  logic [ENT_W-1:0]  headEntry;
  logic              reqFire;
  logic              instFire;
  logic              redirectEff;
  logic              rspDrop;
  logic              rspLive;
  logic              pushEn;
  logic              haltPushed;
  logic              haltPopped;

  assign redirectEff = redirect_valid && (state != HALTED);
  assign rspDrop     = imem_rsp_valid && (dropCnt != '0);
  assign rspLive     = imem_rsp_valid && (dropCnt == '0);
  assign pushEn      = rspLive && !redirect_valid && (state == FETCH);
  assign haltPushed  = pushEn && (imem_rsp_data == DATA_W'(HALT_INSTR));
  assign instFire    = inst_valid && inst_ready;
  assign haltPopped  = instFire && (inst == DATA_W'(HALT_INSTR));

  // Live outstanding requests plus buffered words must fit the FIFO; the extra
  // inflight bound keeps the counters in range across back-to-back redirects.
  assign occupancy      = {1'b0, inflight - dropCnt} + {1'b0, fifoCount};
  assign imem_req_valid = !reset && (state == FETCH) && !redirect_valid
                        && (inflight < CNT_W'(FIFO_DEPTH))
                        && (occupancy < OCC_W'(FIFO_DEPTH));
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign inflightNext   = inflight + CNT_W'(reqFire) - CNT_W'(imem_rsp_valid);

  // rspPc tracks the address of the oldest non-dropped response.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      rspPc    <= RESET_PC;
      inflight <= '0;
      dropCnt  <= '0;
    end else begin
      inflight <= inflightNext;
      if (redirectEff) begin
        fetchPc <= redirect_pc;
        rspPc   <= redirect_pc;
        dropCnt <= inflightNext;
      end else begin
        if (reqFire) fetchPc <= fetchPc + ADDR_W'(PC_STEP);
        if (rspDrop)      dropCnt <= dropCnt - CNT_W'(1);
        else if (rspLive) rspPc   <= rspPc + ADDR_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:    if (!redirectEff && haltPushed) stateNext = STOPPING;
      STOPPING: begin
        if (redirectEff)     stateNext = FETCH;
        else if (haltPopped) stateNext = HALTED;
      end
      HALTED:   stateNext = HALTED;
      default:  stateNext = FETCH;
    endcase
  end

  assign halted   = (state == HALTED);
  assign dbgState = state;

  ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirectEff),
    .push     (pushEn),
    .pushData ({rspPc, imem_rsp_data}),
    .pop      (instFire),
    .popData  (headEntry),
    .popValid (inst_valid),
    .count    (fifoCount)
  );

  assign pc   = headEntry[ENT_W-1:DATA_W];
  assign inst = headEntry[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory model.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        halted;
  ifu_state_e  dbgState;

  instr_fetch_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .halted         (halted),
    .dbgState       (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned memLat = 1;
  logic        haltOn = 1'b0;
  logic [31:0] haltAddr = '0;
  pend_t       pendQ[$];
  logic [31:0] reqLog[$];
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (haltOn && a == haltAddr) return 32'hFFFF_FFFF;
    return a + 32'h100;
  endfunction

  // One cycle: record handshakes just before the edge, then present the
  // memory response for the next edge at the falling edge.
  task automatic step();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pendQ.push_back('{addr: imem_req_addr, due: cyc + 1 + memLat});
      reqLog.push_back(imem_req_addr);
    end
    if (inst_valid && inst_ready) begin
      check("sb_expect_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_deliver", {pc, inst}, exp_q.pop_front());
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pendQ.size() != 0 && pendQ[0].due == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memData(pendQ[0].addr);
      void'(pendQ.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    haltOn = 1'b0;
    step();
    step();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_pc_inst", {pc, inst}, 64'h0);
    check("rst_halted", halted, 0);
    pendQ.delete();
    reqLog.delete();
    exp_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    reset = 1'b0;
    #1;
    check("rst_first_req_valid", imem_req_valid, 1);
    check("rst_first_req_addr", imem_req_addr, 32'h0);
  endtask

  initial begin
    int n;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;

    // streaming with 1-cycle memory
    doReset();
    memLat = 1;
    inst_ready = 1'b1;
    exp_q.push_back({32'h0, 32'h100});
    exp_q.push_back({32'h4, 32'h104});
    step();
    check("stream_latency", inst_valid, 0);
    step();
    check("stream_0", {pc, inst}, {32'h0, 32'h100});
    step();
    check("stream_1", {pc, inst}, {32'h4, 32'h104});
    step();
    check("stream_2", {pc, inst}, {32'h8, 32'h108});
    inst_ready = 1'b0;
    check("stream_sb", exp_q.size(), 0);

    // backpressure: fill, stall, then drain in order
    doReset();
    repeat (10) step();
    check("bp_req_count", reqLog.size(), 4);
    for (int i = 0; i < 4; i++) check("bp_req_addr", reqLog[i], 64'(i * 4));
    check("bp_req_stall", imem_req_valid, 0);
    reqLog.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 4), 32'(i * 4 + 'h100)});
    inst_ready = 1'b1;
    repeat (4) step();
    inst_ready = 1'b0;
    check("bp_drain", exp_q.size(), 0);
    check("bp_resume_addr", reqLog[0], 32'h10);
    check("bp_head_after", {pc, inst}, {32'h10, 32'h110});

    // redirect with two requests in flight, 3-cycle memory
    doReset();
    memLat = 3;
    inst_ready = 1'b1;
    step();
    step();
    check("rd_inflight_reqs", reqLog.size(), 2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("rd_req_blocked", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("rd_new_req_valid", imem_req_valid, 1);
    check("rd_new_req_addr", imem_req_addr, 32'h40);
    check("rd_inst_valid_low", inst_valid, 0);
    exp_q.push_back({32'h40, 32'h140});
    exp_q.push_back({32'h44, 32'h144});
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    inst_ready = 1'b0;
    check("rd_drain", exp_q.size(), 0);

    // halt word at 0x8
    doReset();
    memLat = 1;
    haltOn = 1'b1;
    haltAddr = 32'h8;
    inst_ready = 1'b1;
    exp_q.push_back({32'h0, 32'h100});
    exp_q.push_back({32'h4, 32'h104});
    exp_q.push_back({32'h8, 32'hFFFF_FFFF});
    n = 0;
    while (!(inst_valid && pc == 32'h8) && n < 20) begin
      step();
      n++;
    end
    check("halt_head", {pc, inst}, {32'h8, 32'hFFFF_FFFF});
    check("halt_not_yet", halted, 0);
    step();
    check("halt_set", halted, 1);
    check("halt_inst_valid", inst_valid, 0);
    check("halt_req_count", reqLog.size(), 4);
    repeat (4) step();
    check("halt_no_more_req", reqLog.size(), 4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    #1;
    check("halt_redirect_req", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    step();
    check("halt_stays", halted, 1);
    check("halt_state", 64'(dbgState), 64'(HALTED));
    check("halt_redirect_ignored", reqLog.size(), 4);
    check("halt_sb", exp_q.size(), 0);

    // redirect coinciding with a head handshake and a response
    doReset();
    memLat = 1;
    inst_ready = 1'b1;
    exp_q.push_back({32'h0, 32'h100});
    step();
    step();
    check("rc_head", {pc, inst}, {32'h0, 32'h100});
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    #1;
    check("rc_fifo_empty", inst_valid, 0);
    check("rc_head_consumed", exp_q.size(), 0);
    check("rc_new_req_valid", imem_req_valid, 1);
    check("rc_new_req_addr", imem_req_addr, 32'h200);
    exp_q.push_back({32'h200, 32'h300});
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    inst_ready = 1'b0;
    check("rc_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of `cpu`. It owns the fetch PC, issues in-order read requests to instruction memory and buffers the returned words in a small prefetch FIFO. It then delivers `{pc, instruction}` pairs to the core over a valid/ready handshake. It also handles control-flow redirects from the core and stops fetching on a halt instruction.

## Interface
Parameters:
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction width.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  ADDR_W  fetch address.
- `imem_rsp_valid`  in  1  read data valid; responses return in request order, no backpressure.
- `imem_rsp_data`  in  DATA_W  read data.
- `redirect_valid`  in  1  core requests fetch restart.
- `redirect_pc`  in  ADDR_W  restart address, word aligned.
- `inst_valid`  out  1  head entry valid.
- `inst_ready`  in  1  core consumes head entry.
- `inst`  out  DATA_W  head instruction.
- `pc`  out  ADDR_W  address of head instruction.
- `halted`  out  1  halt instruction consumed; fetch stopped.

## Operation
- FSM states: FETCH, STOPPING, HALTED. Reset enters FETCH.
- `fetch_pc` starts at RESET_PC and advances by 4 on each request handshake.
- `inflight` counts requests accepted without a response. `drop_cnt` counts inflight responses to discard.
- Issue condition: state==FETCH, `!redirect_valid`, and `(inflight - drop_cnt) + fifo_count < FIFO_DEPTH`.
- `imem_req_valid` equals the issue condition, combinational. `imem_req_addr = fetch_pc`.
- Response handling:
  - If `drop_cnt > 0`, discard the response and decrement `drop_cnt`.
  - Otherwise, if `redirect_valid` is high this cycle, discard it.
  - Otherwise, push `{addr, data}` into the FIFO. The address comes from a parallel in-order address queue, or is recomputed from the issue PC.
- Halt detection: a pushed word equal to `HALT_INSTR` moves FETCH→STOPPING. No further requests are issued and later non-dropped responses are discarded.
- STOPPING→HALTED when the core handshakes the halt entry (`inst_valid & inst_ready` with `inst==HALT_INSTR`). `halted` is registered: it goes to 1 the cycle after that handshake.
- Redirect in FETCH or STOPPING:
  - flush the FIFO;
  - `fetch_pc <= redirect_pc`;
  - `drop_cnt <= inflight_next`, i.e. inflight minus any response arriving this cycle;
  - state <= FETCH.
- Redirect in HALTED is ignored; only `reset` leaves HALTED.
- Redirect coinciding with an `inst` handshake: the handshake completes (the core owns that instruction), then the flush applies.
- `inflight` saturation is impossible by construction (bounded by FIFO_DEPTH); its width is clog2(FIFO_DEPTH)+1.
- PC arithmetic is modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is legal and silent.

## Timing
- Reset values: `imem_req_valid`=0 during reset cycle, `inst_valid`=0, `inst`=0, `pc`=0, `halted`=0, `inflight`=`drop_cnt`=0, FIFO empty.
- First request: `imem_req_valid`=1 with `imem_req_addr`=RESET_PC in the first cycle with `reset` low.
- Response→`inst_valid` latency: 1 cycle (FIFO write, registered head).
- With 1-cycle memory and `inst_ready`=1: one instruction delivered per cycle sustained.
- FIFO full and pop in the same cycle: push is allowed.
- Redirect→new request: request for `redirect_pc` appears the cycle after `redirect_valid`.
- Redirect→`inst_valid`: 0 in the cycle after `redirect_valid`.
- Reset mid-operation: all state cleared next edge. Responses to pre-reset requests are the memory's responsibility; memory is reset together with this block.

## Structure
- Package `ifu_pkg` holds:
  - `ifu_state_e` enum {FETCH, STOPPING, HALTED};
  - `HALT_INSTR` = 32'hFFFF_FFFF;
  - `PC_STEP` = 4.
- Sub-module `ifu_fifo`: synchronous FIFO (parameters width, depth) with a flush input and count output. It stores `{pc, inst}` and is reused for the address queue.

## Test plan
- Reset: hold `reset` 2 cycles → all outputs 0; first cycle after, req addr 0x0.
- Streaming: 1-cycle memory returns addr+0x100, `inst_ready`=1 → `inst` 0x100,0x104,0x108 on consecutive cycles with `pc` 0x0,0x4,0x8.
- Backpressure: `inst_ready`=0 → exactly 4 requests (0x0–0xC), then `imem_req_valid`=0. Release → 4 entries in order, then fetch resumes at 0x10.
- Redirect with 2 in flight (3-cycle memory), `redirect_pc`=0x40 → both stale responses dropped, next request 0x40, first delivered `pc`=0x40.
- Halt: memory returns 0xFFFF_FFFF at pc 0x8 → no request after it. Entries 0x0,0x4,0x8 delivered. `halted`=1 the cycle after the 0x8 handshake. A later redirect is ignored.
- Redirect same cycle as head handshake and as a response → handshake entry counted consumed, response dropped, FIFO empty next cycle.
